exec_stage: RTL

Execute-stage sequencer for the 16-bit core. It accepts one decoded instruction at a time from the decode stage over a valid/ready handshake and reads its operands from an internal 8×16 register file. It drives the combinational ALU with those operands, captures the ALU result, and writes it back while updating the zero and negative flags. It sits between decode and the ALU; the ALU is instantiated beside it, not inside it.

---
 rtl/exec_pkg.sv | 21 ++
 rtl/exec_regfile.sv | 35 +++
 rtl/exec_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared constants and types for the execute stage: opcodes, widths and FSM states.
package exec_pkg;

    localparam int DATA_W    = 16;
    localparam int NREGS_DEF = 8;
    localparam int OP_W      = 3;

    localparam logic [OP_W-1:0] OP_SHIFT = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b100;
    localparam logic [OP_W-1:0] OP_AND   = 3'b101;
    localparam logic [OP_W-1:0] OP_OR    = 3'b110;
    localparam logic [OP_W-1:0] OP_NOT   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } exec_state_t;

endpackage

// File: rtl/exec_regfile.sv
// General register file: two operand read ports, one debug read port, one write port.
module exec_regfile #(
    parameter int NREGS = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] ra_idx,
    output logic [W-1:0]             ra_data,
    input  logic [$clog2(NREGS)-1:0] rb_idx,
    output logic [W-1:0]             rb_data,
    input  logic [$clog2(NREGS)-1:0] dbg_idx,
    output logic [W-1:0]             dbg_data,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic [W-1:0]             wd
);

    logic [W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data  = regs[ra_idx];
    assign rb_data  = regs[rb_idx];
    assign dbg_data = regs[dbg_idx];

endmodule

// File: rtl/exec_stage.sv
// Execute-stage sequencer: accepts one decoded instruction, reads operands,
// drives the external ALU, captures its result and writes it back with flags.
//
// state | meaning
// IDLE  | ready for an instruction; fields latched on acceptance
// READ  | operands fetched from the register file
// EXEC  | operand registers drive the ALU; its result is captured
// WB    | result written to rd, wb_valid high; flags commit at the end
module exec_stage
    import exec_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int W     = DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_op,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [$clog2(NREGS)-1:0] in_rs,
    input  logic [$clog2(NREGS)-1:0] in_rt,
    input  logic                     in_use_imm,
    input  logic [W-1:0]             in_imm,
    output logic [W-1:0]             alu_operand1,
    output logic [W-1:0]             alu_operand2,
    output logic [OP_W-1:0]          alu_operation,
    input  logic [W-1:0]             alu_result,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_reg,
    output logic [W-1:0]             wb_data,
    output logic                     flag_zero,
    output logic                     flag_neg,
    input  logic [$clog2(NREGS)-1:0] dbg_sel,
    output logic [W-1:0]             dbg_data
);

    localparam int AW = $clog2(NREGS);

    exec_state_t     state;
    logic [OP_W-1:0] op_q;
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   rs_q;
    logic [AW-1:0]   rt_q;
    logic            use_imm_q;
    logic [W-1:0]    imm_q;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    result;
    logic            wb_valid_q;
    logic            zero_q;
    logic            neg_q;
    logic [W-1:0]    rs_data;
    logic [W-1:0]    rt_data;

    exec_regfile #(.NREGS(NREGS), .W(W)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .ra_idx   (rs_q),
        .ra_data  (rs_data),
        .rb_idx   (rt_q),
        .rb_data  (rt_data),
        .dbg_idx  (dbg_sel),
        .dbg_data (dbg_data),
        .we       (wb_valid_q),
        .wa       (rd_q),
        .wd       (result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            use_imm_q  <= 1'b0;
            imm_q      <= '0;
            opa        <= '0;
            opb        <= '0;
            result     <= '0;
            wb_valid_q <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q      <= in_op;
                        rd_q      <= in_rd;
                        rs_q      <= in_rs;
                        rt_q      <= in_rt;
                        use_imm_q <= in_use_imm;
                        imm_q     <= in_imm;
                        state     <= READ;
                    end
                end
                READ: begin
                    opa   <= rs_data;
                    opb   <= use_imm_q ? imm_q : rt_data;
                    state <= EXEC;
                end
                EXEC: begin
                    result     <= alu_result;
                    wb_valid_q <= 1'b1;
                    state      <= WB;
                end
                WB: begin
                    // register write happens in the regfile on this same edge
                    wb_valid_q <= 1'b0;
                    zero_q     <= (result == '0);
                    neg_q      <= result[W-1];
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state == IDLE) && !reset;
    assign alu_operand1  = opa;
    assign alu_operand2  = opb;
    assign alu_operation = op_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg        = rd_q;
    assign wb_data       = result;
    assign flag_zero     = zero_q;
    assign flag_neg      = neg_q;

endmodule
